stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Mode controller and MM:SS BCD counter for the lab3 stopwatch. Sequences the clock-divider
//  outputs (1 Hz count, 2 Hz adjust, 4 Hz blink) under button control: run, pause, clear,
//  manual adjust. Sits between clock divider / debouncers and the 7-segment display driver.
// PARAMETERS
//  MAX_MIN   59  highest minutes value; MAX_MIN:59 + 1 s wraps to 00:00 (range 1..99)
// PORTS
//  clk        in   1  system clock, 100 MHz
//  rst_n      in   1  synchronous active-low reset, sampled on rising clk
//  one        in   1  1 Hz divider output (square wave, clk-synchronous)
//  two        in   1  2 Hz divider output
//  four       in   1  4 Hz divider output
//  btn_pause  in   1  debounced 1-cycle pulse: start/pause toggle
//  btn_clr    in   1  debounced 1-cycle pulse: clear to 00:00, stop
//  adj        in   1  level: 1 = adjust mode
//  sel        in   1  level, adjust field: 0 = minutes, 1 = seconds
//  btn_lap    in   1  debounced 1-cycle pulse: lap freeze toggle (ignored unless LAP_EN)
//  min_hi     out  4  minutes tens digit, BCD
//  min_lo     out  4  minutes units digit, BCD
//  sec_hi     out  4  seconds tens digit, BCD (0..5)
//  sec_lo     out  4  seconds units digit, BCD
//  running    out  1  1 while in RUN
//  blink      out  1  1 = display selected field, 0 = blank it
//  lap_active out  1  1 while display frozen (always 0 without LAP_EN)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE, all digits 0, running 0, blink 1, lap_active 0,
//   edge-detect history regs cleared to 0 (a divider output already high at release = edge).
//  Tick edges: rise_x = x & ~x_q, x_q registered every cycle; action occurs on the same clk
//   edge that first samples x high. Exactly one action per divider period.
//  States / transitions (priority btn_clr > adj > btn_pause, evaluated every cycle):
//   any   -- btn_clr            -> IDLE, digits <= 00:00 (also clears lap freeze)
//   IDLE  -- adj=1 -> ADJUST;  btn_pause -> RUN
//   RUN   -- adj=1 -> ADJUST;  btn_pause -> PAUSE
//   PAUSE -- adj=1 -> ADJUST;  btn_pause -> RUN
//   ADJUST-- adj=0 -> PAUSE (btn_pause ignored while adj=1)
//  RUN counting on rise_one: sec_lo 9->0 carries sec_hi; sec 59->00 carries minutes;
//   minutes MAX_MIN->00 wrap. Digits never leave BCD range.
//  ADJUST on rise_two: increment only selected field, no carry; seconds 59->00,
//   minutes MAX_MIN->00. sel change takes effect on next rise_two.
//  blink: 1 outside ADJUST; forced 1 on ADJUST entry; toggles on each rise_four in ADJUST.
//  Simultaneous: rise_one and btn_pause in same RUN cycle -> count applied, then PAUSE.
//   rise_one with btn_clr -> clr wins, 00:00. rise_one on ADJUST-entry cycle -> not counted.
//  running = (state==RUN), registered, no combinational paths input->output.
// CONFIGURATION
//  LAP_EN defined: btn_lap in RUN/PAUSE toggles lap_active. On set, display regs snapshot
//   internal count and hold; internal count keeps running. On clear, display re-tracks
//   count on the same edge. Entering ADJUST or btn_clr clears lap_active.
//  LAP_EN undefined: btn_lap ignored, lap_active tied 0, display = internal count, no
//   snapshot registers synthesised.
// TESTING
//  Bench drives one/two/four directly as short square waves (not the real divider).
//  1 reset+start: rst_n low 2 cycles, btn_pause, 125 rise_one -> 02:05, running=1.
//  2 wrap: adjust to MAX_MIN:59 (59:59), leave adj, btn_pause, 1 rise_one -> 00:00.
//  3 adjust: from 00:00, adj=1 sel=1, 61 rise_two -> 00:01 (59->00 wrap, no carry);
//    sel=0, 3 rise_two -> 03:01; blink toggles each rise_four; adj=0 -> PAUSE, blink=1.
//  4 pause race: RUN at 00:09, rise_one + btn_pause same cycle -> 00:10, running=0;
//    further rise_one -> stays 00:10.
//  5 clear priority: RUN at 07:30, btn_clr + adj=1 + rise_one same cycle -> IDLE, 00:00.
//  6 LAP_EN: RUN 00:05, btn_lap, 10 rise_one -> outputs 00:05, lap_active=1; btn_lap -> 00:15.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// MM:SS BCD stopwatch controller: run/pause/clear/adjust FSM driven by 1/2/4 Hz divider edges; all outputs registered.
// Optional lap freeze under `LAP_EN; without it btn_lap is ignored and lap_active is tied low.
module stopwatch_ctrl #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       one,
  input  logic       two,
  input  logic       four,
  input  logic       btn_pause,
  input  logic       btn_clr,
  input  logic       adj,
  input  logic       sel,
  input  logic       btn_lap,
  output logic [3:0] min_hi,
  output logic [3:0] min_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] sec_lo,
  output logic       running,
  output logic       blink,
  output logic       lap_active
);

  localparam logic [3:0] MAX_MIN_HI = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_LO = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSE  = 2'd2,
    S_ADJUST = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] min_hi;
    logic [3:0] min_lo;
    logic [3:0] sec_hi;
    logic [3:0] sec_lo;
  } bcd_time_t;

  state_t    state_q, state_d;
  bcd_time_t cnt_q, cnt_d;
  logic      blink_q, blink_d;
  logic      one_q, two_q, four_q;
  logic      rise_one, rise_two, rise_four;
  logic      count_en, adj_en;

  // seconds wrap 59 -> 00; caller decides whether that carries into minutes
  function automatic logic [7:0] inc_sec(input logic [7:0] s);
    logic [7:0] r;
    if (s[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (s[7:4] == 4'd5) ? 4'd0 : s[7:4] + 4'd1;
    end else begin
      r = {s[7:4], s[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] inc_min(input logic [7:0] m);
    logic [7:0] r;
    if (m == {MAX_MIN_HI, MAX_MIN_LO}) begin
      r = 8'h00;
    end else if (m[3:0] == 4'd9) begin
      r = {m[7:4] + 4'd1, 4'd0};
    end else begin
      r = {m[7:4], m[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign rise_one  = one  & ~one_q;
  assign rise_two  = two  & ~two_q;
  assign rise_four = four & ~four_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (btn_clr) begin
      state_d = S_IDLE;
    end else if (adj) begin
      state_d = S_ADJUST;
    end else begin
      case (state_q)
        S_IDLE:   if (btn_pause) state_d = S_RUN;
        S_RUN:    if (btn_pause) state_d = S_PAUSE;
        S_PAUSE:  if (btn_pause) state_d = S_RUN;
        S_ADJUST: state_d = S_PAUSE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // A tick that lands on the ADJUST-entry cycle is dropped: adj masks counting.
  assign count_en = (state_q == S_RUN) && rise_one && !adj;
  assign adj_en   = (state_q == S_ADJUST) && adj && rise_two;

  always_comb begin
    cnt_d = cnt_q;
    if (btn_clr) begin
      cnt_d = '0;
    end else if (count_en) begin
      {cnt_d.sec_hi, cnt_d.sec_lo} = inc_sec({cnt_q.sec_hi, cnt_q.sec_lo});
      if ({cnt_q.sec_hi, cnt_q.sec_lo} == 8'h59) begin
        {cnt_d.min_hi, cnt_d.min_lo} = inc_min({cnt_q.min_hi, cnt_q.min_lo});
      end
    end else if (adj_en) begin
      if (sel) begin
        {cnt_d.sec_hi, cnt_d.sec_lo} = inc_sec({cnt_q.sec_hi, cnt_q.sec_lo});
      end else begin
        {cnt_d.min_hi, cnt_d.min_lo} = inc_min({cnt_q.min_hi, cnt_q.min_lo});
      end
    end
  end

  always_comb begin
    blink_d = blink_q;
    if (state_d != S_ADJUST || state_q != S_ADJUST) begin
      blink_d = 1'b1;
    end else if (rise_four) begin
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      blink_q <= 1'b1;
      one_q   <= 1'b0;
      two_q   <= 1'b0;
      four_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      one_q   <= one;
      two_q   <= two;
      four_q  <= four;
    end
  end

`ifdef LAP_EN
  logic      lap_q, lap_d;
  bcd_time_t disp_q, disp_d;

  always_comb begin
    lap_d = lap_q;
    if (btn_clr || state_d == S_ADJUST) begin
      lap_d = 1'b0;
    end else if (btn_lap && (state_q == S_RUN || state_q == S_PAUSE)) begin
      lap_d = ~lap_q;
    end
  end

  // Freeze takes the value shown before this edge; unfreezing re-tracks the live count immediately.
  always_comb begin
    disp_d = cnt_d;
    if (lap_d) begin
      disp_d = lap_q ? disp_q : cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_q  <= 1'b0;
      disp_q <= '0;
    end else begin
      lap_q  <= lap_d;
      disp_q <= disp_d;
    end
  end

  // FSM: outputs
  always_comb begin
    {min_hi, min_lo, sec_hi, sec_lo} = disp_q;
    running    = (state_q == S_RUN);
    blink      = blink_q;
    lap_active = lap_q;
  end
`else
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;

  // FSM: outputs
  always_comb begin
    {min_hi, min_lo, sec_hi, sec_lo} = cnt_q;
    running    = (state_q == S_RUN);
    blink      = blink_q;
    lap_active = 1'b0;
  end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: single-cycle vector table plus multi-cycle scenario sequences.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       one = 1'b0, two = 1'b0, four = 1'b0;
  logic       btn_pause = 1'b0, btn_clr = 1'b0, adj = 1'b0, sel = 1'b0, btn_lap = 1'b0;
  logic [3:0] min_hi, min_lo, sec_hi, sec_lo;
  logic       running, blink, lap_active;

  logic       adj_r = 1'b0, sel_r = 1'b0;
  int         total = 0;
  int         bad = 0;

  stopwatch_ctrl #(.MAX_MIN(59)) dut (
    .clk(clk), .rst_n(rst_n), .one(one), .two(two), .four(four),
    .btn_pause(btn_pause), .btn_clr(btn_clr), .adj(adj), .sel(sel), .btn_lap(btn_lap),
    .min_hi(min_hi), .min_lo(min_lo), .sec_hi(sec_hi), .sec_lo(sec_lo),
    .running(running), .blink(blink), .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  // inputs packed as {one,two,four,pause,clr,adj,sel,lap}; flags as {running,blink,lap_active}
  typedef struct packed {
    logic [7:0]  in_bits;
    logic [15:0] digits;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs [18];

  task automatic step(input logic [7:0] v);
    @(negedge clk);
    {one, two, four, btn_pause, btn_clr, adj, sel, btn_lap} = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] exp_dig, input logic [2:0] exp_flags);
    logic [18:0] got;
    logic [18:0] expv;
    got  = {min_hi, min_lo, sec_hi, sec_lo, running, blink, lap_active};
    expv = {exp_dig, exp_flags};
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got time=%h run/blink/lap=%b, want time=%h run/blink/lap=%b",
               name, got[18:3], got[2:0], expv[18:3], expv[2:0]);
    end
  endtask

  task automatic do_reset();
    adj_r = 1'b0;
    sel_r = 1'b0;
    rst_n = 1'b0;
    step(8'h00);
    step(8'h00);
    chk("reset_state", 16'h0000, 3'b010);
    rst_n = 1'b1;
  endtask

  task automatic set_adj(input logic a, input logic s);
    adj_r = a;
    sel_r = s;
    step({5'b00000, adj_r, sel_r, 1'b0});
  endtask

  // kind: 0 = one, 1 = two, 2 = four; each pulse is one cycle high, one cycle low
  task automatic pulse(input int kind, input int n);
    for (int i = 0; i < n; i++) begin
      step({kind == 0, kind == 1, kind == 2, 2'b00, adj_r, sel_r, 1'b0});
      step({5'b00000, adj_r, sel_r, 1'b0});
    end
  endtask

  task automatic press_pause();
    step({3'b000, 1'b1, 1'b0, adj_r, sel_r, 1'b0});
  endtask

  task automatic press_lap();
    step({5'b00000, adj_r, sel_r, 1'b1});
  endtask

  initial begin
    vecs[0]  = '{8'b0000_0000, 16'h0000, 3'b010};
    vecs[1]  = '{8'b1000_0000, 16'h0000, 3'b010};
    vecs[2]  = '{8'b0001_0000, 16'h0000, 3'b110};
    vecs[3]  = '{8'b1000_0000, 16'h0001, 3'b110};
    vecs[4]  = '{8'b1000_0000, 16'h0001, 3'b110};
    vecs[5]  = '{8'b0000_0000, 16'h0001, 3'b110};
    vecs[6]  = '{8'b1001_0000, 16'h0002, 3'b010};
    vecs[7]  = '{8'b0000_0000, 16'h0002, 3'b010};
    vecs[8]  = '{8'b1000_0000, 16'h0002, 3'b010};
    vecs[9]  = '{8'b0000_0110, 16'h0002, 3'b010};
    vecs[10] = '{8'b0110_0110, 16'h0003, 3'b000};
    vecs[11] = '{8'b0000_0110, 16'h0003, 3'b000};
    vecs[12] = '{8'b0010_0110, 16'h0003, 3'b010};
    vecs[13] = '{8'b0100_0100, 16'h0103, 3'b010};
    vecs[14] = '{8'b0000_0000, 16'h0103, 3'b010};
    vecs[15] = '{8'b0001_0000, 16'h0103, 3'b110};
    vecs[16] = '{8'b1000_1000, 16'h0000, 3'b010};
    vecs[17] = '{8'b0000_0000, 16'h0000, 3'b010};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].in_bits);
      chk($sformatf("vec%0d", i), vecs[i].digits, vecs[i].flags);
    end

    // reset, start, 125 s
    do_reset();
    press_pause();
    pulse(0, 125);
    chk("run_125s", 16'h0205, 3'b110);

    // wrap from MAX_MIN:59
    do_reset();
    set_adj(1'b1, 1'b0);
    pulse(1, 59);
    set_adj(1'b1, 1'b1);
    pulse(1, 59);
    chk("adj_to_5959", 16'h5959, 3'b010);
    set_adj(1'b0, 1'b0);
    press_pause();
    pulse(0, 1);
    chk("wrap_0000", 16'h0000, 3'b110);

    // adjust fields and blink
    do_reset();
    set_adj(1'b1, 1'b1);
    chk("adj_entry_blink", 16'h0000, 3'b010);
    pulse(1, 61);
    chk("adj_sec_wrap", 16'h0001, 3'b010);
    set_adj(1'b1, 1'b0);
    pulse(1, 3);
    chk("adj_min", 16'h0301, 3'b010);
    pulse(2, 1);
    chk("blink_off", 16'h0301, 3'b000);
    pulse(2, 1);
    chk("blink_on", 16'h0301, 3'b010);
    pulse(2, 1);
    set_adj(1'b0, 1'b0);
    chk("adj_exit_blink", 16'h0301, 3'b010);
    press_pause();
    pulse(0, 1);
    chk("resume_after_adj", 16'h0302, 3'b110);

    // tick and pause in the same cycle
    do_reset();
    press_pause();
    pulse(0, 9);
    chk("run_0009", 16'h0009, 3'b110);
    step(8'b1001_0000);
    chk("pause_race", 16'h0010, 3'b010);
    step(8'h00);
    pulse(0, 3);
    chk("paused_hold", 16'h0010, 3'b010);

    // clear beats adjust and tick
    do_reset();
    set_adj(1'b1, 1'b0);
    pulse(1, 7);
    set_adj(1'b1, 1'b1);
    pulse(1, 30);
    set_adj(1'b0, 1'b0);
    press_pause();
    chk("run_0730", 16'h0730, 3'b110);
    step(8'b1000_1100);
    chk("clr_priority", 16'h0000, 3'b010);
    step(8'h00);
    pulse(0, 2);
    chk("idle_no_count", 16'h0000, 3'b010);

    // lap freeze
    do_reset();
    press_pause();
    pulse(0, 5);
    press_lap();
`ifdef LAP_EN
    chk("lap_set", 16'h0005, 3'b111);
    pulse(0, 10);
    chk("lap_frozen", 16'h0005, 3'b111);
    press_lap();
    chk("lap_release", 16'h0015, 3'b110);
`else
    chk("lap_ignored", 16'h0005, 3'b110);
    pulse(0, 10);
    chk("lap_ignored_run", 16'h0015, 3'b110);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
